// File: rtl/dmem_resp_pkg.sv
// Shared types and defaults for the data-memory response block:
// FSM state encoding, default geometry/latency and an alignment helper.
package dmem_resp_pkg;

   localparam int DMEM_DEPTH_DEF   = 64;
   localparam int DMEM_LATENCY_DEF = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } dmem_state_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, registered read, no reset.
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] idx_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_dffer.sv
// Flop with enable and asynchronous active-high reset to zero.
module dmem_dffer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_o <= '0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency data memory for the M stage: captures one request, waits
// LATENCY cycles, then completes with a one-cycle MemReadyM pulse.
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH   = DMEM_DEPTH_DEF,
   parameter int LATENCY = DMEM_LATENCY_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemReadyM,
   output logic        MemErrM,
   output logic        MemStallM,
   output dmem_state_e dbg_state_o
);

   localparam int         AW       = $clog2(DEPTH);
   localparam int         CW       = AW + 35;
   localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

   dmem_state_e   state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          rd_sel_q, rd_sel_d;
   logic          capture_en;
   logic          access_en;
   logic          misalign;
   logic [CW-1:0] cap_d, cap_q;
   logic          wr_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   arr_rdata;
   logic          unused_addr_hi;

   // Address bits above the array wrap are intentionally dropped.
   assign unused_addr_hi = ^ALUOutM[31:AW+2];

   assign capture_en = (state_q == S_IDLE) && MemReqM;
   assign cap_d      = {MemWriteM, ALUOutM[AW+1:0], WriteDataM};
   assign {wr_q, addr_q, wdata_q} = cap_q;

   dmem_dffer #(.W(CW)) u_capture (
      .clk  (clk),
      .rst  (reset),
      .en_i (capture_en),
      .d_i  (cap_d),
      .q_o  (cap_q)
   );

   assign misalign  = is_misaligned(addr_q[1:0]);
   assign access_en = (state_q == S_WAIT) && (cnt_q == 3'd0);

   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk     (clk),
      .we_i    (access_en && wr_q && !misalign),
      .re_i    (access_en && !wr_q && !misalign),
      .idx_i   (addr_q[AW+1:2]),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_sel_d = rd_sel_q;
      case (state_q)
         S_IDLE: begin
            if (MemReqM) begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = S_DONE;
               // A misaligned load blanks the output until the next load.
               if (!wr_q) begin
                  rd_sel_d = !misalign;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         rd_sel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   assign MemReadyM   = (state_q == S_DONE);
   assign MemErrM     = MemReadyM && misalign;
   assign MemStallM   = MemReqM && !MemReadyM;
   assign ReadDataM   = rd_sel_q ? arr_rdata : 32'h0;
   assign dbg_state_o = state_q;

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit words in the array (power of two, 16..1024).
REQ-002 Parameter LATENCY, default 2, SHALL set the number of wait cycles between acceptance and response (1..7).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 MemReqM  input  1  SHALL be the memory-stage request valid, held high until MemReadyM.
REQ-006 MemWriteM  input  1  SHALL select a store (1) or a load (0), held stable with MemReqM.
REQ-007 ALUOutM  input  32  SHALL be the byte address, held stable with MemReqM.
REQ-008 WriteDataM  input  32  SHALL be the store data, held stable with MemReqM.
REQ-009 ReadDataM  output  32  SHALL be the load data, valid while MemReadyM=1.
REQ-010 MemReadyM  output  1  SHALL pulse high for exactly one cycle to complete a request.
REQ-011 MemErrM  output  1  SHALL be high with MemReadyM when the completed request was misaligned.
REQ-012 MemStallM  output  1  SHALL equal MemReqM & ~MemReadyM (combinational) to stall F/D/E/M.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, DONE; reset state IDLE.
REQ-014 IDLE with MemReqM=1 SHALL capture write flag, address, data, load counter with LATENCY-1, and go to WAIT.
REQ-015 WAIT SHALL decrement the counter each cycle; at counter 0 go to DONE, performing the array access on that edge.
REQ-016 DONE SHALL assert MemReadyM for one cycle and then return to IDLE unconditionally.
REQ-017 Request first seen in cycle 0 SHALL see MemReadyM in cycle LATENCY+1; back-to-back requests SHALL have one IDLE bubble (period LATENCY+2).
REQ-018 Word index SHALL be ALUOutM[log2(DEPTH)+1:2]; upper address bits ignored (address wraps modulo 4*DEPTH).
REQ-019 Store SHALL write the captured data to the indexed word; ReadDataM SHALL keep its previous value.
REQ-020 Load SHALL update ReadDataM with the indexed word, held until the next completed load.
REQ-021 Captured address[1:0] != 0 SHALL suppress the store (array unchanged), force ReadDataM to 0 for a load, and set MemErrM in DONE.
REQ-022 Input changes while in WAIT or DONE SHALL be ignored (captured values only).
REQ-023 MemReqM=0 in IDLE SHALL leave all state and outputs unchanged.

Reset
REQ-024 Reset SHALL force state IDLE, counter 0, ReadDataM 0, MemReadyM 0, MemErrM 0, capture registers 0.
REQ-025 Reset during WAIT or DONE SHALL abort the request with no array write and no MemReadyM pulse.
REQ-026 Array contents SHALL NOT be cleared by reset.

Structure
REQ-027 State encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and LATENCY/DEPTH defaults SHALL live in the shared memory package.
REQ-028 The storage SHALL be a separate sub-module dmem_array (synchronous write, registered read, no reset).
REQ-029 The capture registers SHALL use the team flop-with-enable-and-reset primitive.

Verification
REQ-030 Store 0xDEADBEEF to 0x10, then load 0x10 -> MemReadyM cycle 3 each (LATENCY=2), ReadDataM=0xDEADBEEF, MemErrM=0.
REQ-031 MemReqM held 6 cycles from cycle 0 -> MemStallM=1 cycles 0-2, MemReadyM=1 only cycle 3, second completion cycle 7.
REQ-032 Store 0x11111111 to 0x12 -> MemErrM=1 with MemReadyM; load 0x10 returns the prior word unchanged.
REQ-033 Store 0xA5A5A5A5 to 0x100 (DEPTH=64), load 0x000 -> ReadDataM=0xA5A5A5A5 (wrap).
REQ-034 Reset asserted in WAIT of a store to 0x20 holding 0x5 -> no MemReadyM, state IDLE, later load 0x20 returns 0x5.
REQ-035 ALUOutM changed to 0x40 during WAIT of a load from 0x10 -> ReadDataM is word 0x10.
